// File: rtl/crc_frame_sched.sv
`timescale 1ns/1ps
// Two-requester round-robin frame sequencer around a byte-wide CRC-8 (poly 0x2F, MSB-first).
// Optional idle-gap watchdog: define CRC_TIMEOUT_EN (adds parameter TO_CYC).
module crc_frame_sched #(
  parameter logic [7:0] SEED    = 8'hFF,
  parameter int         MAX_LEN = 64
`ifdef CRC_TIMEOUT_EN
  , parameter int       TO_CYC  = 255
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ch0_vld,
  input  logic [7:0] ch0_data,
  input  logic       ch0_last,
  input  logic       ch0_chk,
  output logic       ch0_rdy,
  input  logic       ch1_vld,
  input  logic [7:0] ch1_data,
  input  logic       ch1_last,
  input  logic       ch1_chk,
  output logic       ch1_rdy,
  output logic       res_vld,
  input  logic       res_rdy,
  output logic       res_id,
  output logic [7:0] res_crc,
  output logic       res_ok,
  output logic       res_err
);

  localparam int         NCH    = 2;
  localparam logic [7:0] POLY   = 8'h2F;
  localparam logic [7:0] MAX_M1 = 8'(MAX_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [7:0] crc8_byte(input logic [7:0] x);
    logic [7:0] c;
    c = x;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
    return c;
  endfunction

  state_t     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;
  logic [7:0] crc_q, crc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       chk_q, chk_d;
  logic       ok_q, ok_d;
  logic       err_q, err_d;

  logic [NCH-1:0]      vld, lst, chk;
  logic [NCH-1:0][7:0] dat;
  assign vld = {ch1_vld, ch0_vld};
  assign lst = {ch1_last, ch0_last};
  assign chk = {ch1_chk, ch0_chk};
  assign dat = {ch1_data, ch0_data};

  logic       busy, sel_vld, sel_lst, acc, frm_chk;
  logic [7:0] sel_dat, crc_nxt;
  assign busy    = (state_q == RUN) || (state_q == DRAIN);
  assign sel_vld = vld[gnt_q];
  assign sel_lst = lst[gnt_q];
  assign sel_dat = dat[gnt_q];
  assign acc     = busy && sel_vld;
  // mode is latched from the first accepted byte; later chk inputs are don't-care
  assign frm_chk = (cnt_q == 8'd0) ? chk[gnt_q] : chk_q;
  assign crc_nxt = crc8_byte(crc_q ^ sel_dat);

`ifdef CRC_TIMEOUT_EN
  localparam logic [7:0] TO_M1 = 8'(TO_CYC - 1);
  logic [7:0] gap_q, gap_d;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    ok_d    = ok_q;
    err_d   = err_q;
`ifdef CRC_TIMEOUT_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      IDLE: if (|vld) begin
        gnt_d   = (&vld) ? ~last_q : vld[1];
        crc_d   = SEED;
        cnt_d   = 8'd0;
        chk_d   = 1'b0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        state_d = RUN;
`ifdef CRC_TIMEOUT_EN
        gap_d   = 8'd0;
`endif
      end
      RUN: if (acc) begin
        cnt_d = cnt_q + 8'd1;
        chk_d = frm_chk;
        if (sel_lst) begin
          state_d = DONE;
          if (frm_chk) ok_d = (sel_dat == crc_q);
          else         crc_d = crc_nxt;
        end else begin
          crc_d = crc_nxt;
          if (cnt_q == MAX_M1) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: if (acc && sel_lst) state_d = DONE;
      DONE: if (res_rdy) begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef CRC_TIMEOUT_EN
    // watchdog abandons the frame outright; no drain of the remainder
    if (busy) begin
      if (acc) gap_d = 8'd0;
      else begin
        gap_d = gap_q + 8'd1;
        if (gap_q == TO_M1) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      crc_q   <= 8'h00;
      cnt_q   <= 8'd0;
      chk_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef CRC_TIMEOUT_EN
      gap_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
`ifdef CRC_TIMEOUT_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign ch0_rdy = busy && !gnt_q;
  assign ch1_rdy = busy &&  gnt_q;
  assign res_vld = (state_q == DONE);
  assign res_id  = gnt_q;
  assign res_crc = crc_q;
  assign res_ok  = ok_q && chk_q && !err_q;
  assign res_err = err_q;

endmodule

// File: tb/tb_crc_frame_sched.sv
`timescale 1ns/1ps
// Directed bench for crc_frame_sched: vector table of whole frames plus hand sequences
// for round-robin/back-pressure, mid-frame reset and the idle-gap watchdog.
module tb_crc_frame_sched;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       ch0_vld = 0, ch0_last = 0, ch0_chk = 0, ch0_rdy;
  logic       ch1_vld = 0, ch1_last = 0, ch1_chk = 0, ch1_rdy;
  logic [7:0] ch0_data = 0, ch1_data = 0;
  logic       res_vld, res_rdy = 0, res_id, res_ok, res_err;
  logic [7:0] res_crc;

  int tests = 0, fails = 0;

  crc_frame_sched #(
    .SEED(8'hFF), .MAX_LEN(4)
`ifdef CRC_TIMEOUT_EN
    , .TO_CYC(8)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_vld(ch0_vld), .ch0_data(ch0_data), .ch0_last(ch0_last), .ch0_chk(ch0_chk), .ch0_rdy(ch0_rdy),
    .ch1_vld(ch1_vld), .ch1_data(ch1_data), .ch1_last(ch1_last), .ch1_chk(ch1_chk), .ch1_rdy(ch1_rdy),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_id(res_id), .res_crc(res_crc),
    .res_ok(res_ok), .res_err(res_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic            ch;
    logic            chk;
    int              n;
    logic [5:0][7:0] b;
    logic [7:0]      crc;
    logic            ok;
    logic            err;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ch, input logic v, input logic [7:0] d, input logic l, input logic c);
    if (ch) begin ch1_vld = v; ch1_data = d; ch1_last = l; ch1_chk = c; end
    else    begin ch0_vld = v; ch0_data = d; ch0_last = l; ch0_chk = c; end
  endtask

  function automatic logic rdy_of(input logic ch);
    return ch ? ch1_rdy : ch0_rdy;
  endfunction

  // bs holds byte0 in its top byte
  function automatic vec_t mk(input logic ch, input logic chk, input int n, input logic [47:0] bs,
                              input logic [7:0] crc, input logic ok, input logic err);
    vec_t v;
    v.ch = ch; v.chk = chk; v.n = n; v.crc = crc; v.ok = ok; v.err = err;
    for (int i = 0; i < 6; i++) v.b[i] = bs[47-8*i -: 8];
    return v;
  endfunction

  task automatic consume(input string nm);
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
    check({nm, " res_vld_drop"}, res_vld, 0);
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    int lat, i, guard;
    @(negedge clk);
    drive(v.ch, 1'b1, v.b[0], v.n == 1, v.chk);
    lat = 0;
    while (!rdy_of(v.ch) && lat < 20) begin @(negedge clk); lat++; end
    check({nm, " grant_lat"}, lat, 1);
    i = 0; guard = 0;
    while (i < v.n && guard < 50) begin
      if (rdy_of(v.ch)) begin
        i++;
        @(negedge clk);
        if (i < v.n) drive(v.ch, 1'b1, v.b[i], i == v.n - 1, v.chk);
      end else begin
        @(negedge clk);
        guard++;
      end
    end
    drive(v.ch, 1'b0, 8'h00, 1'b0, 1'b0);
    check({nm, " bytes_taken"}, i, v.n);
    check({nm, " res_vld_lat"}, res_vld, 1);
    guard = 0;
    while (!res_vld && guard < 20) begin @(negedge clk); guard++; end
    check({nm, " res_id"},  res_id,  v.ch);
    check({nm, " res_crc"}, res_crc, v.crc);
    check({nm, " res_ok"},  res_ok,  v.ok);
    check({nm, " res_err"}, res_err, v.err);
    consume(nm);
  endtask

  vec_t tv[11];

  initial begin
    int cnt;
    tv[0]  = mk(0, 0, 1, 48'h00_00_00_00_00_00, 8'h42, 0, 0);
    tv[1]  = mk(1, 1, 2, 48'h00_42_00_00_00_00, 8'h42, 1, 0);
    tv[2]  = mk(1, 1, 2, 48'h00_43_00_00_00_00, 8'h42, 0, 0);
    tv[3]  = mk(0, 0, 2, 48'hFF_00_00_00_00_00, 8'h00, 0, 0);
    tv[4]  = mk(1, 0, 1, 48'h00_00_00_00_00_00, 8'h42, 0, 0);
    tv[5]  = mk(0, 1, 1, 48'hFF_00_00_00_00_00, 8'hFF, 1, 0);
    tv[6]  = mk(0, 1, 1, 48'hFE_00_00_00_00_00, 8'hFF, 0, 0);
    tv[7]  = mk(1, 0, 4, 48'hFF_00_00_00_00_00, 8'h00, 0, 0);
    tv[8]  = mk(0, 1, 4, 48'hFF_00_00_00_00_00, 8'h00, 1, 0);
    tv[9]  = mk(0, 0, 6, 48'hFF_00_00_00_11_22, 8'h00, 0, 1);
    tv[10] = mk(1, 1, 5, 48'hFF_00_00_00_00_00, 8'h00, 0, 1);

    #1;
    check("rst ch0_rdy", ch0_rdy, 0);
    check("rst ch1_rdy", ch1_rdy, 0);
    check("rst res_vld", res_vld, 0);
    check("rst res_id",  res_id,  0);
    check("rst res_crc", res_crc, 8'h00);
    check("rst res_ok",  res_ok,  0);
    check("rst res_err", res_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 11; k++) run_frame(tv[k], $sformatf("vec%0d", k));

    // mid-frame asynchronous reset
    @(negedge clk);
    drive(0, 1'b1, 8'h00, 1'b0, 1'b0);
    cnt = 0;
    while (!ch0_rdy && cnt < 20) begin @(negedge clk); cnt++; end
    @(negedge clk);
    drive(0, 1'b1, 8'h11, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst ch0_rdy", ch0_rdy, 0);
    check("midrst res_vld", res_vld, 0);
    check("midrst res_crc", res_crc, 8'h00);
    check("midrst res_id",  res_id,  0);
    check("midrst res_ok",  res_ok,  0);
    check("midrst res_err", res_err, 0);
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(tv[0], "post_rst");

    // fresh reset so the last-served pointer is back at ch1
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 8'h00, 1'b1, 1'b0);
    drive(1, 1'b1, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cnt = 0;
      @(negedge clk);
      while (!res_vld && cnt < 20) begin @(negedge clk); cnt++; end
      if (k > 0) check($sformatf("rr%0d b2b_lat", k), cnt, 1);
      check($sformatf("rr%0d res_id", k),  res_id,  k % 2);
      check($sformatf("rr%0d res_crc", k), res_crc, 8'h42);
      check($sformatf("rr%0d rdy_idle", k), {ch1_rdy, ch0_rdy}, 2'b00);
      if (k == 0) begin
        for (int h = 0; h < 5; h++) begin
          @(negedge clk);
          check($sformatf("hold%0d", h), {res_vld, res_id, res_crc, res_ok, res_err}, {1'b1, 1'b0, 8'h42, 1'b0, 1'b0});
        end
      end
      if (k == 2) begin
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
      end
      res_rdy = 1'b1;
      @(negedge clk);
      res_rdy = 1'b0;
    end

    // stalled frame on ch1: one byte, then the requester goes quiet
    @(negedge clk);
    drive(1, 1'b1, 8'h00, 1'b0, 1'b0);
    cnt = 0;
    while (!ch1_rdy && cnt < 20) begin @(negedge clk); cnt++; end
    @(negedge clk);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef CRC_TIMEOUT_EN
    cnt = 0;
    while (!res_vld && cnt < 30) begin @(negedge clk); cnt++; end
    check("to gap_cycles", cnt, 8);
    check("to res_err", res_err, 1);
    check("to res_ok",  res_ok,  0);
    check("to res_id",  res_id,  1);
    check("to res_crc", res_crc, 8'h42);
    consume("to");
`else
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (res_vld) cnt++;
    end
    check("noto no_result", cnt, 0);
    drive(1, 1'b1, 8'h00, 1'b1, 1'b0);
    cnt = 0;
    while (!ch1_rdy && cnt < 20) begin @(negedge clk); cnt++; end
    @(negedge clk);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("noto res_vld", res_vld, 1);
    check("noto res_crc", res_crc, 8'hB8);
    check("noto res_err", res_err, 0);
    consume("noto");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
